// File: rtl/gshare_pht_pkg.sv
// Shared types and default sizing for the gshare pattern history table.
package gshare_pht_pkg;

  localparam int unsigned XLEN                  = 32;
  localparam int unsigned PHT_N                 = 2;
  localparam int unsigned PHT_IDX_BITS          = 10;
  localparam int unsigned BRANCH_HISTORY_REG_SZ = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_ctr_e;

endpackage

// File: rtl/gshare_pht.sv
// Gshare PHT: 2-bit saturating counters indexed by pc ^ history, N combinational lookups, one update per cycle.
// Define PHT_FWD_EN to forward a same-cycle update to matching lookups.
module gshare_pht
  import gshare_pht_pkg::*;
#(
  parameter int unsigned N        = PHT_N,
  parameter int unsigned IDX_BITS = PHT_IDX_BITS,
  parameter int unsigned DEPTH    = BRANCH_HISTORY_REG_SZ
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N-1:0]                  rd_en,
  input  logic [N-1:0][XLEN-1:0]        rd_pc,
  input  logic [DEPTH-1:0]              rd_bhr,
  input  logic                          wr_en,
  input  logic [XLEN-1:0]               wr_pc,
  input  logic [DEPTH-1:0]              wr_bhr,
  input  logic                          wr_taken,
  output logic [N-1:0]                  pred_taken,
  output logic [N-1:0][IDX_BITS-1:0]    pred_idx
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  if (DEPTH > IDX_BITS) begin : g_depth_chk
    $error("gshare_pht: DEPTH must not exceed IDX_BITS");
  end

  function automatic logic [IDX_BITS-1:0] pht_hash(input logic [XLEN-1:0]  pc,
                                                   input logic [DEPTH-1:0] bhr);
    return pc[IDX_BITS+1:2] ^ IDX_BITS'(bhr);
  endfunction

  function automatic pht_ctr_e sat_next(input pht_ctr_e c, input logic taken);
    pht_ctr_e n;
    n = c;
    case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = WNT;
    endcase
    return n;
  endfunction

  pht_ctr_e              ctr [ENTRIES];
  logic [IDX_BITS-1:0]   wr_idx;
  pht_ctr_e              wr_next;
  logic [N-1:0][IDX_BITS-1:0] rd_idx;
  pht_ctr_e              rd_ctr [N];
  logic                  unused_pc_bits;

  // Only pc[IDX_BITS+1:2] feeds the hash.
  assign unused_pc_bits = ^{rd_pc, wr_pc};

  assign wr_idx  = pht_hash(wr_pc, wr_bhr);
  assign wr_next = sat_next(ctr[wr_idx], wr_taken);

  // Table storage: reset to weakly not-taken, at most one counter trained per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        ctr[e] <= WNT;
      end
    end else if (wr_en) begin
      assert (!$isunknown(wr_pc));
      ctr[wr_idx] <= wr_next;
    end
  end

  // Zero-latency lookup; outputs held at zero while in reset.
  always_comb begin
    rd_idx     = '0;
    pred_taken = '0;
    pred_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rd_ctr[i] = WNT;
    end
    for (int unsigned i = 0; i < N; i++) begin
      rd_idx[i] = pht_hash(rd_pc[i], rd_bhr);
      rd_ctr[i] = ctr[rd_idx[i]];
`ifdef PHT_FWD_EN
      if (wr_en && (rd_idx[i] == wr_idx)) begin
        rd_ctr[i] = wr_next;
      end
`endif
      if (!reset) begin
        pred_taken[i] = rd_en[i] & rd_ctr[i][1];
        pred_idx[i]   = rd_idx[i];
      end
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Scoreboard bench for gshare_pht: driver queues hand-computed lookups, negedge monitor checks them.
module tb_gshare_pht;
  import gshare_pht_pkg::*;

  localparam int unsigned TN  = 2;
  localparam int unsigned TIB = 10;
  localparam int unsigned TD  = 4;

  logic                    clock;
  logic                    reset;
  logic [TN-1:0]           rd_en;
  logic [TN-1:0][XLEN-1:0] rd_pc;
  logic [TD-1:0]           rd_bhr;
  logic                    wr_en;
  logic [XLEN-1:0]         wr_pc;
  logic [TD-1:0]           wr_bhr;
  logic                    wr_taken;
  logic [TN-1:0]           pred_taken;
  logic [TN-1:0][TIB-1:0]  pred_idx;

  typedef struct {
    logic [TN-1:0]  pt;
    logic [TIB-1:0] i0;
    logic [TIB-1:0] i1;
    string          name;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  gshare_pht #(.N(TN), .IDX_BITS(TIB), .DEPTH(TD)) dut (
    .clock      (clock),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_pc      (rd_pc),
    .rd_bhr     (rd_bhr),
    .wr_en      (wr_en),
    .wr_pc      (wr_pc),
    .wr_bhr     (wr_bhr),
    .wr_taken   (wr_taken),
    .pred_taken (pred_taken),
    .pred_idx   (pred_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: any enabled lookup slot is an output presentation to score.
  always @(negedge clock) begin
    if (rd_en != '0) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_lookup: no queued expectation, pred_taken=%b", pred_taken);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (pred_taken !== e.pt) begin
          errors++;
          $display("FAIL %s pred_taken: got %b want %b", e.name, pred_taken, e.pt);
        end
        checks++;
        if (pred_idx[0] !== e.i0 || pred_idx[1] !== e.i1) begin
          errors++;
          $display("FAIL %s pred_idx: got %h/%h want %h/%h", e.name, pred_idx[0], pred_idx[1],
                   e.i0, e.i1);
        end
      end
    end
  end

  task automatic cyc(input logic rst, input logic [1:0] ren, input logic [31:0] p0,
                     input logic [31:0] p1, input logic [3:0] bhr, input logic we,
                     input logic [31:0] wpc, input logic [3:0] wb, input logic wt,
                     input logic [1:0] ept, input logic [9:0] ei0, input logic [9:0] ei1,
                     input string nm);
    exp_t e;
    reset    = rst;
    rd_en    = ren;
    rd_pc[0] = p0;
    rd_pc[1] = p1;
    rd_bhr   = bhr;
    wr_en    = we;
    wr_pc    = wpc;
    wr_bhr   = wb;
    wr_taken = wt;
    if (ren != '0) begin
      e.pt = ept; e.i0 = ei0; e.i1 = ei1; e.name = nm;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] pc, input logic [3:0] b, input logic t);
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 4'h0, 1'b1, pc, b, t, 2'b00, 10'h0, 10'h0, "");
  endtask

  // Read slot0 at pc0 and slot1 at 0x48 with shared history.
  task automatic rd(input logic [31:0] pc0, input logic [3:0] b, input logic [1:0] ept,
                    input logic [9:0] ei0, input logic [9:0] ei1, input string nm);
    cyc(1'b0, 2'b11, pc0, 32'h48, b, 1'b0, 32'h0, 4'h0, 1'b0, ept, ei0, ei1, nm);
  endtask

  logic fwd_pred;

  initial begin
`ifdef PHT_FWD_EN
    fwd_pred = 1'b1;
`else
    fwd_pred = 1'b0;
`endif
    reset = 1'b1; rd_en = '0; rd_pc = '0; rd_bhr = '0;
    wr_en = 1'b0; wr_pc = '0; wr_bhr = '0; wr_taken = 1'b0;
    @(posedge clock); #1;
    cyc(1'b1, 2'b00, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 2'b00, 10'h0, 10'h0, "");
    // In reset: outputs forced to zero, training ignored.
    cyc(1'b1, 2'b11, 32'h44, 32'h48, 4'h1, 1'b1, 32'h40, 4'h0, 1'b1,
        2'b00, 10'h000, 10'h000, "in_reset");

    // Every entry starts WNT.
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b0, 2'b11, 32'(i) << 2, 32'(1023 - i) << 2, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0,
          2'b00, 10'(i), 10'(1023 - i), "reset_sweep");
    end

    // Saturate up on idx 0x10.
    wr(32'h40, 4'h0, 1'b1); rd(32'h40, 4'h0, 2'b01, 10'h010, 10'h012, "tk1_wt");
    wr(32'h40, 4'h0, 1'b1); rd(32'h40, 4'h0, 2'b01, 10'h010, 10'h012, "tk2_st");
    wr(32'h40, 4'h0, 1'b1); rd(32'h40, 4'h0, 2'b01, 10'h010, 10'h012, "tk3_st_hold");
    // Saturate down.
    wr(32'h40, 4'h0, 1'b0); rd(32'h40, 4'h0, 2'b01, 10'h010, 10'h012, "nt1_wt");
    wr(32'h40, 4'h0, 1'b0); rd(32'h40, 4'h0, 2'b00, 10'h010, 10'h012, "nt2_wnt");
    wr(32'h40, 4'h0, 1'b0); rd(32'h40, 4'h0, 2'b00, 10'h010, 10'h012, "nt3_snt");
    wr(32'h40, 4'h0, 1'b0); rd(32'h40, 4'h0, 2'b00, 10'h010, 10'h012, "nt4_snt_hold");
    wr(32'h40, 4'h0, 1'b1); rd(32'h40, 4'h0, 2'b00, 10'h010, 10'h012, "snt_up_wnt");
    wr(32'h40, 4'h0, 1'b1); rd(32'h40, 4'h0, 2'b01, 10'h010, 10'h012, "wnt_up_wt");

    // Aliasing: 0x44/bhr1 and 0x40/bhr0 both index 0x10; 0x48/bhr0 is 0x12.
    rd(32'h44, 4'h1, 2'b01, 10'h010, 10'h013, "alias_44_b1");
    wr(32'h44, 4'h1, 1'b1);
    rd(32'h40, 4'h0, 2'b01, 10'h010, 10'h012, "alias_st_via_44");
    wr(32'h44, 4'h1, 1'b0);
    wr(32'h44, 4'h1, 1'b0);
    rd(32'h40, 4'h0, 2'b00, 10'h010, 10'h012, "alias_wnt_via_44");

    // Same-cycle read/write of idx 0x10 at WNT.
    cyc(1'b0, 2'b01, 32'h40, 32'h48, 4'h0, 1'b1, 32'h40, 4'h0, 1'b1,
        {1'b0, fwd_pred}, 10'h010, 10'h012, "same_cycle_rw");
    rd(32'h40, 4'h0, 2'b01, 10'h010, 10'h012, "after_rw");

    // Reset inside a taken stream on idx 0x12.
    wr(32'h48, 4'h0, 1'b1);
    cyc(1'b1, 2'b11, 32'h48, 32'h40, 4'h0, 1'b1, 32'h48, 4'h0, 1'b1,
        2'b00, 10'h000, 10'h000, "reset_mid_stream");
    cyc(1'b0, 2'b01, 32'h48, 32'h40, 4'h0, 1'b1, 32'h48, 4'h0, 1'b1,
        {1'b0, fwd_pred}, 10'h012, 10'h010, "post_reset_wnt");
    cyc(1'b0, 2'b11, 32'h48, 32'h40, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0,
        2'b01, 10'h012, 10'h010, "post_reset_resume");

    rd_en = '0; wr_en = 1'b0;
    repeat (3) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unconsumed, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
